fb_swap_ctrl: RTL and testbench

//  Write-side sequencer for the double-buffered framebuffer pair. Accepts a pixel stream

---
 rtl/fb_swap_ctrl.sv | 118 +++++++++++
 tb/tb_fb_swap_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_ctrl.sv
// Write-side sequencer for the double-buffered framebuffer pair; swaps buffers at vblank after a full frame.
// Optional statistics counters (swap_count, miss_count) are enabled by defining FB_SWAP_STATS_EN.
module fb_swap_ctrl #(
  parameter int unsigned DATA_WIDTH   = 20,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned FRAME_PIXELS = 16384
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] px_data,
  input  logic                  px_valid,
  input  logic                  px_last,
  output logic                  px_ready,
  input  logic                  vblank,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic                  fb_we,
  output logic                  selection,
  output logic                  frame_short
`ifdef FB_SWAP_STATS_EN
  ,
  output logic [15:0]           swap_count,
  output logic [15:0]           miss_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    WAIT_VB = 2'd1,
    SWAP    = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] cnt, cnt_d;
  logic                  sel_d, short_d;
  logic                  vblank_q;
  logic                  vb_rise, beat, frame_end;

  assign vb_rise   = vblank & ~vblank_q;
  assign px_ready  = (state == FILL) & ~rst;
  assign beat      = px_valid & px_ready;
  assign frame_end = px_last | (cnt == LAST_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  // Next state, frame counter, buffer selection and short-frame flag
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = selection;
    short_d = frame_short;
    case (state)
      FILL: begin
        if (beat) begin
          if (frame_end) begin
            state_d = WAIT_VB;
            if (px_last && (cnt != LAST_ADDR)) short_d = 1'b1;
          end else begin
            cnt_d = cnt + ADDR_WIDTH'(1);
          end
        end
      end
      WAIT_VB: begin
        if (vb_rise) state_d = SWAP;
      end
      SWAP: begin
        state_d = FILL;
        sel_d   = ~selection;
        cnt_d   = '0;
      end
      default: state_d = FILL;
    endcase
  end

  // Registered write port and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      selection   <= 1'b0;
      frame_short <= 1'b0;
      vblank_q    <= 1'b0;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      fb_wdata    <= '0;
    end else begin
      cnt         <= cnt_d;
      selection   <= sel_d;
      frame_short <= short_d;
      vblank_q    <= vblank;
      fb_we       <= beat;
      if (beat) begin
        fb_waddr <= cnt;
        fb_wdata <= px_data;
      end
    end
  end

`ifdef FB_SWAP_STATS_EN
  // Swap count wraps; miss count (vblank while still filling) saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      swap_count <= '0;
      miss_count <= '0;
    end else begin
      if (state == SWAP) swap_count <= swap_count + 16'd1;
      if ((state == FILL) && vb_rise && (miss_count != 16'hFFFF))
        miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: behavioural frame model checked every cycle plus directed literal checks.
// Set FB_SWAP_STATS_EN to also cover the statistics counters.
module tb_fb_swap_ctrl;

  localparam int unsigned DW = 20;
  localparam int unsigned AW = 14;
  localparam int unsigned FP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] px_data = '0;
  logic          px_valid = 1'b0;
  logic          px_last = 1'b0;
  logic          px_ready;
  logic          vblank = 1'b0;
  logic [DW-1:0] fb_wdata;
  logic [AW-1:0] fb_waddr;
  logic          fb_we;
  logic          selection;
  logic          frame_short;
`ifdef FB_SWAP_STATS_EN
  logic [15:0]   swap_count;
  logic [15:0]   miss_count;
`endif

  fb_swap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .rst(rst), .px_data(px_data), .px_valid(px_valid), .px_last(px_last),
    .px_ready(px_ready), .vblank(vblank), .fb_wdata(fb_wdata), .fb_waddr(fb_waddr),
    .fb_we(fb_we), .selection(selection), .frame_short(frame_short)
`ifdef FB_SWAP_STATS_EN
    , .swap_count(swap_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wq[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Frame-level model: pixels taken this frame, whether the frame is closed and awaiting
  // a fresh vblank edge, and whether the buffer flip happens on the coming edge.
  bit            m_valid = 0;
  bit            m_accept, m_closed, m_flip, m_sel, m_short, m_we, m_vbq;
  int            m_n, m_swaps, m_miss;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("px_ready", 32'(px_ready), 32'(m_accept && !rst));
      chk("fb_we", 32'(fb_we), 32'(m_we));
      chk("selection", 32'(selection), 32'(m_sel));
      chk("frame_short", 32'(frame_short), 32'(m_short));
      if (m_we) begin
        chk("fb_waddr", 32'(fb_waddr), 32'(m_waddr));
        chk("fb_wdata", 32'(fb_wdata), 32'(m_wdata));
      end
`ifdef FB_SWAP_STATS_EN
      chk("swap_count", 32'(swap_count), 32'(m_swaps));
      chk("miss_count", 32'(miss_count), 32'(m_miss));
`endif
      if (fb_we === 1'b1) wq.push_back(int'(fb_waddr));
    end
    // advance the model across the coming rising edge (inputs are stable until then)
    if (rst) begin
      m_accept = 1; m_closed = 0; m_flip = 0; m_n = 0; m_sel = 0; m_short = 0;
      m_we = 0; m_waddr = '0; m_wdata = '0; m_vbq = 0; m_swaps = 0; m_miss = 0;
      m_valid = 1;
    end else if (m_valid) begin
      bit beat, vbr;
      beat  = px_valid && m_accept;
      vbr   = vblank && !m_vbq;
      m_vbq = vblank;
      m_we  = beat;
      if (beat) begin
        m_waddr = AW'(m_n);
        m_wdata = px_data;
      end
      if (m_flip) begin
        m_sel = !m_sel; m_n = 0; m_flip = 0; m_accept = 1;
        m_swaps = (m_swaps + 1) % 65536;
      end else if (m_closed) begin
        if (vbr) begin m_closed = 0; m_flip = 1; end
      end else begin
        if (vbr && m_miss < 65535) m_miss++;
        if (beat) begin
          if (px_last || m_n == FP - 1) begin
            if (px_last && m_n < FP - 1) m_short = 1;
            m_closed = 1; m_accept = 0;
          end else begin
            m_n++;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit done = 0;
    px_data = d; px_last = l; px_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (px_ready) done = 1;
      tick(1);
    end
    px_valid = 1'b0; px_last = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_vb();
    vblank = 1'b1; tick(1);
    vblank = 1'b0; tick(1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(px_ready), 32'd0);
    chk("rst_sel", 32'(selection), 32'd0);
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_waddr", 32'(fb_waddr), 32'd0);
    chk("rst_short", 32'(frame_short), 32'd0);
    rst = 1'b0;

    // full frame with continuous valid, no vblank
    wq.delete();
    px_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin px_data = DW'(32'h12340 + i); tick(1); end
    chk("t1_nwrites", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_addr", 32'(wq[i]), 32'(i));
    chk("t1_sel", 32'(selection), 32'd0);
    chk("t1_ready", 32'(px_ready), 32'd0);

    // vblank edge swaps; selection flips two edges after vblank is raised
    wq.delete();
    pulse_vb();
    chk("t2_sel", 32'(selection), 32'd1);
    chk("t2_ready", 32'(px_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin px_data = DW'(32'h55500 + i); tick(1); end
    px_valid = 1'b0;
    chk("t2_nwrites", 32'(wq.size()), 32'd4);
    chk("t2_first", 32'(wq[0]), 32'd0);

    // short frame via px_last on second beat
    pulse_vb();
    wq.delete();
    send(20'hAAAA1, 1'b0);
    send(20'hAAAA2, 1'b1);
    tick(3);
    chk("t3_nwrites", 32'(wq.size()), 32'd2);
    chk("t3_addr1", 32'(wq[1]), 32'd1);
    chk("t3_short", 32'(frame_short), 32'd1);
    chk("t3_ready", 32'(px_ready), 32'd0);

    // gapped valid: writes mirror beats, contiguous addresses
    pulse_vb();
    wq.delete();
    for (int i = 0; i < 4; i++) begin send(DW'(32'h0BEE0 + i), 1'b0); tick(1); end
    tick(2);
    chk("t5_nwrites", 32'(wq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t5_addr", 32'(wq[i]), 32'(i));
    chk("t5_short_sticky", 32'(frame_short), 32'd1);
    chk("t5_sel", 32'(selection), 32'd1);

    // vblank rising with the final beat must not swap
    pulse_vb();
    for (int i = 0; i < 3; i++) send(DW'(32'hC0DE0 + i), 1'b0);
    vblank = 1'b1;
    send(20'hC0DE3, 1'b0);
    tick(5);
    chk("t4_nosw_sel", 32'(selection), 32'd0);
    chk("t4_nosw_ready", 32'(px_ready), 32'd0);
    vblank = 1'b0; tick(1);
    vblank = 1'b1; tick(2);
    chk("t4_sw_sel", 32'(selection), 32'd1);
    vblank = 1'b0;

    // reset mid-frame with selection=1, then vblank edges while filling
    send(20'h77771, 1'b0);
    send(20'h77772, 1'b0);
    rst = 1'b1; tick(1);
    chk("t6_sel", 32'(selection), 32'd0);
    chk("t6_we", 32'(fb_we), 32'd0);
    chk("t6_waddr", 32'(fb_waddr), 32'd0);
    chk("t6_short", 32'(frame_short), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) pulse_vb();
    chk("t6_ready", 32'(px_ready), 32'd1);
`ifdef FB_SWAP_STATS_EN
    chk("t6_miss", 32'(miss_count), 32'd3);
    chk("t6_swaps", 32'(swap_count), 32'd0);
`endif
    wq.delete();
    send(20'h3C3C3, 1'b0);
    tick(1);
    chk("t6_restart_addr", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 32'd0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
